// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundles the producer-side controls and the display
// pin outputs of seg7_scan_driver.
//   en_i         scan enable
//   load_i       one-cycle strobe capturing din_i into the shadow register
//   din_i        packed digit codes, digit 0 in din_i[3:0]
//   blank_lz_i   leading-zero blanking enable
//   seg_o        segments {a,b,c,d,e,f,g}, a is bit 6
//   an_o         one-hot digit enable
//   digit_idx_o  index of the digit currently lit
//   frame_done_o one-cycle pulse when the last digit slot ends
// master: value producer / board side; slave: the scan driver.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    en_i;
  logic                    load_i;
  logic [4*NUM_DIGITS-1:0] din_i;
  logic                    blank_lz_i;
  logic [6:0]              seg_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [IDXW-1:0]         digit_idx_o;
  logic                    frame_done_o;

  modport master (
    output en_i, load_i, din_i, blank_lz_i,
    input  seg_o, an_o, digit_idx_o, frame_done_o
  );

  modport slave (
    input  en_i, load_i, din_i, blank_lz_i,
    output seg_o, an_o, digit_idx_o, frame_done_o
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit multiplexed 7-segment driver. A prescaler sets
// how long each digit is lit, a scan counter walks the digits, and a
// shadow/active register pair makes value updates take effect only at a
// frame boundary so a frame never shows a mix of old and new digits.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     seg7_scan_driver_if.slave (controls in, segment/anode pins out)
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          HEX_MODE       = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input logic               clk_i,
  input logic               rst_ni,
  seg7_scan_driver_if.slave bus
);
  localparam int unsigned IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW   = $clog2(REFRESH_DIV);
  localparam int unsigned DW   = 4 * NUM_DIGITS;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         active_q, active_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  tick, wrap;
  logic                  lz_run;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic [3:0]            cur_code;
  logic                  cur_blank;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = HEX_MODE ? 7'b1110111 : 7'b0000001;
      4'hB:    s = HEX_MODE ? 7'b0011111 : 7'b0000001;
      4'hC:    s = HEX_MODE ? 7'b1001110 : 7'b0000001;
      4'hD:    s = HEX_MODE ? 7'b0111101 : 7'b0000001;
      4'hE:    s = HEX_MODE ? 7'b1001111 : 7'b0000001;
      default: s = HEX_MODE ? 7'b1000111 : 7'b0000001;
    endcase
    return s;
  endfunction

  always_comb begin
    tick = bus.en_i && (presc_q == PRESC_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    presc_d = presc_q;
    if (bus.en_i) presc_d = tick ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    // Reading the old shadow here is what makes a load on the wrap edge
    // land one frame later.
    shadow_d = bus.load_i ? bus.din_i : shadow_q;
    active_d = wrap ? shadow_q : active_q;
    frame_d  = wrap;

    // Walk from the most significant digit down; a digit is blankable while
    // it and everything above it is zero. Digit 0 is always shown.
    lz_run    = 1'b1;
    blank_vec = '0;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      lz_run       = lz_run & (active_q[4*(k-1) +: 4] == 4'h0);
      blank_vec[k-1] = lz_run & (k > 1);
    end

    cur_code  = '0;
    cur_blank = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDXW'(k)) begin
        cur_code  = active_q[4*k +: 4];
        cur_blank = blank_vec[k];
      end
    end

    seg_d = '0;
    an_d  = '0;
    if (bus.en_i) begin
      an_d  = NUM_DIGITS'(1) << idx_q;
      seg_d = (bus.blank_lz_i && cur_blank) ? 7'b0000000 : decode(cur_code);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      seg_q    <= '0;
      an_q     <= '0;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.seg_o        = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign bus.an_o         = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
  assign bus.digit_idx_o  = idx_q;
  assign bus.frame_done_o = frame_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor to the team's single-digit BCD-to-7-segment decoder.
- Drives an N-digit common-segment multiplexed display from one packed BCD/hex word.
- Contains:
  - a refresh prescaler,
  - a digit scan counter,
  - a shadow/active register pair that gives tear-free updates,
  - optional leading-zero blanking and hex mode.
- Sits between the datapath (value producer) and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000, clock cycles each digit is lit; must be >= 2.
- HEX_MODE, 0, 1 = decode codes 10..15 as A,b,C,d,E,F; 0 = show codes 10..15 as a dash (segment g only).
- SEG_ACTIVE_LOW, 0, 1 = invert all seg bits at the output.
- AN_ACTIVE_LOW, 0, 1 = invert all an bits at the output.

Ports:
- clk, in, 1, system clock; all logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, scan enable.
- load, in, 1, single-cycle strobe that captures din into the shadow register.
- din, in, 4*NUM_DIGITS, packed digit codes; digit 0 (least significant) is din[3:0].
- blank_lz, in, 1, leading-zero blanking enable.
- seg, out, 7, segment bits {a,b,c,d,e,f,g}; a is bit 6.
- an, out, NUM_DIGITS, one-hot digit enable.
- digit_idx, out, clog2(NUM_DIGITS) (min 1), index of the digit currently lit.
- frame_done, out, 1, one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - prescaler = 0, digit_idx = 0, shadow = 0, active = 0, frame_done = 0.
  - seg and an at logical off, i.e. all 0 before polarity inversion.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while en=1, then wraps to 0.
  - "tick" means prescaler == REFRESH_DIV-1 and en=1.
- Scan:
  - On tick, digit_idx advances by 1.
  - When digit_idx == NUM_DIGITS-1 at tick, digit_idx wraps to 0, frame_done=1 for the next cycle, and active <= shadow on the same edge.
- Load:
  - load=1 sets shadow <= din on that edge.
  - The value becomes visible only at the next frame wrap.
  - load coincident with wrap: active takes the OLD shadow; the new value appears one frame later.
  - Back-to-back loads: the last one before the wrap wins.
- en=0:
  - Prescaler and digit_idx hold their values.
  - seg and an are forced off on the next edge; frame_done = 0.
  - Re-asserting en resumes the scan from the held state.
- Output registration:
  - seg and an are registered from the current digit_idx and active register.
  - Latency is 1 cycle after a digit_idx change.
  - an is one-hot at bit digit_idx.
- Decode (logical segments a..g, 1 = lit):
  - 0 = abcdef; 1 = bc; 2 = abdeg; 3 = abcdg; 4 = bcfg.
  - 5 = acdfg; 6 = acdefg; 7 = abc; 8 = abcdefg; 9 = abcdfg.
  - HEX_MODE=1: A = abcefg; b = cdefg; C = adef; d = bcdeg; E = adefg; F = aefg.
  - HEX_MODE=0: codes 10..15 give g only.
- Leading-zero blanking:
  - Applies when blank_lz=1.
  - Digit k (k >= 1) is blanked (seg = 0, but an still asserted) if active digit k and every more-significant digit are all 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Evaluated on the active register, not on din.
- Polarity inversion is applied last, so the reset and off states honour SEG_ACTIVE_LOW and AN_ACTIVE_LOW.
- NUM_DIGITS=1: digit_idx stays 0; frame_done pulses every tick; active updates every tick.
- Reset asserted mid-scan or mid-load returns everything to reset state immediately; any pending shadow value is lost.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, all polarity params 0 unless noted):
- Reset, then en=1, no load:
  - digit_idx steps 0,1,2,3,0, changing every 4 cycles.
  - an steps 0001,0010,0100,1000, lagging digit_idx by 1 cycle.
  - seg = 1111110 on every digit.
  - frame_done pulses once every 16 cycles.
- load with din=16'h1234 mid-frame:
  - Display unchanged until the wrap.
  - Next frame shows seg 0110011 (4), 1111001 (3), 1101101 (2), 0110000 (1) for idx 0..3.
- din=16'h0070, blank_lz=1:
  - idx 0 gives 1111110; idx 1 gives 1110000.
  - idx 2 and 3 give seg = 0000000 with an still one-hot.
  - Same value with blank_lz=0 shows 1111110 on idx 2 and 3.
- din=16'hAF00:
  - HEX_MODE=0: idx 2 and 3 give 0000001.
  - HEX_MODE=1: idx 2 gives 1000111 (F) and idx 3 gives 1110111 (A).
- en dropped at idx 2 for 10 cycles:
  - seg and an are 0 from the next cycle.
  - digit_idx holds at 2; frame_done stays 0.
  - On re-enable, scan resumes at idx 2 with the prescaler at its held count.
- SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1:
  - Reset gives seg = 1111111 and an = 1111.
  - Asserting rst_n low mid-frame returns outputs to this state asynchronously.
  - After release, digit 0 shows 0000001.
